// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART program loader.
// Covers the loader state encoding, header length and word/checksum helpers.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN0 = 3'd0,
    LEN1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam int LEN_BYTES  = 2;
  localparam int BYTE_IDX_W = 3;

  function automatic int bytes_per_word(input int word_width);
    return word_width / 8;
  endfunction

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] rx_byte);
    return acc ^ rx_byte;
  endfunction

endpackage

// File: rtl/uart_prog_loader_word_assembler.sv
// Places one received byte into its lane of the word being assembled.
// The lane follows arrival order and the configured byte order.
module word_assembler
  import loader_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [WORD_WIDTH-1:0] partial_word,
  input  logic [7:0]            rx_byte,
  input  logic [BYTE_IDX_W-1:0] byte_idx,
  output logic [WORD_WIDTH-1:0] asm_word,
  output logic                  last_byte
);

  localparam int BPW = bytes_per_word(WORD_WIDTH);

  logic [BYTE_IDX_W-1:0] lane_s;

  // Select the destination lane and merge the byte into the partial word.
  always_comb begin
    if (BIG_ENDIAN) begin
      lane_s = BYTE_IDX_W'(BPW - 1) - byte_idx;
    end else begin
      lane_s = byte_idx;
    end
    asm_word = partial_word;
    asm_word[8*lane_s +: 8] = rx_byte;
  end

  assign last_byte = (byte_idx == BYTE_IDX_W'(BPW - 1));

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: parses a length-prefixed image from the UART byte stream,
// writes words to instruction memory and releases the CPU once verified.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter bit BIG_ENDIAN  = 1'b0,
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  load_err,
  output logic [15:0]           word_count
);

  localparam int HDR_W = 8 * LEN_BYTES;

  state_t                state_r, state_nx_s;
  logic [7:0]            len_lo_r;
  logic [HDR_W-1:0]      n_hdr_s;
  logic [HDR_W-1:0]      n_words_r;
  logic [15:0]           widx_r;
  logic [BYTE_IDX_W-1:0] byte_idx_r;
  logic [WORD_WIDTH-1:0] word_r, word_nx_s;
  logic [7:0]            csum_r;
  logic                  last_byte_s, data_byte_s, word_done_s, last_word_s, reload_ok_s;
  logic                  cpu_rst_s, load_done_s, load_err_s;
  logic                  mem_we_r, cpu_rst_r, load_done_r, load_err_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [WORD_WIDTH-1:0] mem_wdata_r;
  logic [15:0]           word_count_r;

  word_assembler #(
    .WORD_WIDTH (WORD_WIDTH),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_asm (
    .partial_word (word_r),
    .rx_byte      (rx_data),
    .byte_idx     (byte_idx_r),
    .asm_word     (word_nx_s),
    .last_byte    (last_byte_s)
  );

  assign n_hdr_s     = {rx_data, len_lo_r};
  assign data_byte_s = rx_valid & (state_r == DATA);
  assign word_done_s = data_byte_s & last_byte_s;
  assign last_word_s = (widx_r == (n_words_r - 16'd1));
  assign reload_ok_s = reload & ((state_r == DONE) | (state_r == ERR));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= LEN0;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      LEN0: begin
        if (rx_valid) state_nx_s = LEN1;
        else          state_nx_s = state_r;
      end
      LEN1: begin
        if (!rx_valid)                               state_nx_s = state_r;
        else if ({16'd0, n_hdr_s} > 32'(DEPTH))      state_nx_s = ERR;
        else if (n_hdr_s == 16'd0)                   state_nx_s = CHECKSUM_EN ? CSUM : DONE;
        else                                         state_nx_s = DATA;
      end
      DATA: begin
        if (word_done_s && last_word_s) state_nx_s = CHECKSUM_EN ? CSUM : DONE;
        else                            state_nx_s = state_r;
      end
      CSUM: begin
        if (!rx_valid)              state_nx_s = state_r;
        else if (rx_data == csum_r) state_nx_s = DONE;
        else                        state_nx_s = ERR;
      end
      DONE, ERR: begin
        if (reload) state_nx_s = LEN0;
        else        state_nx_s = state_r;
      end
      default: state_nx_s = ERR;
    endcase
  end

  // Status outputs decoded from the state being entered, then registered.
  always_comb begin
    cpu_rst_s   = 1'b1;
    load_done_s = 1'b0;
    load_err_s  = 1'b0;
    case (state_nx_s)
      DONE: begin
        cpu_rst_s   = 1'b0;
        load_done_s = 1'b1;
      end
      ERR:     load_err_s = 1'b1;
      default: cpu_rst_s  = 1'b1;
    endcase
  end

  // Status output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rst_r   <= 1'b1;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      cpu_rst_r   <= cpu_rst_s;
      load_done_r <= load_done_s;
      load_err_r  <= load_err_s;
    end
  end

  // Header capture, word assembly, checksum and memory write sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_lo_r     <= 8'd0;
      n_words_r    <= 16'd0;
      widx_r       <= 16'd0;
      byte_idx_r   <= '0;
      word_r       <= '0;
      csum_r       <= 8'd0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      word_count_r <= 16'd0;
    end else begin
      mem_we_r <= word_done_s;
      if (reload_ok_s) begin
        word_count_r <= 16'd0;
        mem_addr_r   <= '0;
        csum_r       <= 8'd0;
        byte_idx_r   <= '0;
        widx_r       <= 16'd0;
      end else begin
        if ((state_r == LEN0) && rx_valid) len_lo_r <= rx_data;
        if ((state_r == LEN1) && rx_valid) begin
          n_words_r  <= n_hdr_s;
          byte_idx_r <= '0;
          widx_r     <= 16'd0;
        end
        if (data_byte_s) begin
          word_r     <= word_nx_s;
          csum_r     <= csum_update(csum_r, rx_data);
          byte_idx_r <= last_byte_s ? '0 : byte_idx_r + BYTE_IDX_W'(1);
        end
        if (word_done_s) begin
          mem_wdata_r <= word_nx_s;
          widx_r      <= widx_r + 16'd1;
        end
        // The address holds at the top cell so nothing past DEPTH-1 is ever presented.
        if (mem_we_r) begin
          word_count_r <= word_count_r + 16'd1;
          if (mem_addr_r != ADDR_WIDTH'(DEPTH - 1)) mem_addr_r <= mem_addr_r + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign cpu_rst    = cpu_rst_r;
  assign load_done  = load_done_r;
  assign load_err   = load_err_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed boot images plus random
// images compared against an image-level reference model.
module tb_uart_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reload = 1'b0;
  logic        rx_valid_le = 1'b0, rx_valid_be = 1'b0;
  logic [7:0]  rx_data = 8'd0;

  logic        mem_we_le, cpu_rst_le, load_done_le, load_err_le;
  logic [5:0]  mem_addr_le;
  logic [31:0] mem_wdata_le;
  logic [15:0] word_count_le;
  logic        mem_we_be, cpu_rst_be, load_done_be, load_err_be;
  logic [5:0]  mem_addr_be;
  logic [31:0] mem_wdata_be;
  logic [15:0] word_count_be;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  img_q[$];
  logic [5:0]  le_a[$], be_a[$];
  logic [31:0] le_d[$], be_d[$];
  int          exp_a[$];
  logic [31:0] exp_d[$];
  bit          exp_done, exp_err;
  int          exp_wc;
  int          we_long = 0;
  bit          we_prev_le = 1'b0, we_prev_be = 1'b0;

  uart_prog_loader dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid_le), .rx_data(rx_data), .reload(reload),
    .mem_we(mem_we_le), .mem_addr(mem_addr_le), .mem_wdata(mem_wdata_le),
    .cpu_rst(cpu_rst_le), .load_done(load_done_le), .load_err(load_err_le),
    .word_count(word_count_le)
  );

  uart_prog_loader #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .rx_valid(rx_valid_be), .rx_data(rx_data), .reload(reload),
    .mem_we(mem_we_be), .mem_addr(mem_addr_be), .mem_wdata(mem_wdata_be),
    .cpu_rst(cpu_rst_be), .load_done(load_done_be), .load_err(load_err_be),
    .word_count(word_count_be)
  );

  always #5 clk = ~clk;

  // Write monitor; a strobe held for two samples is recorded as a long pulse.
  always @(negedge clk) begin
    if (mem_we_le) begin le_a.push_back(mem_addr_le); le_d.push_back(mem_wdata_le); end
    if (mem_we_be) begin be_a.push_back(mem_addr_be); be_d.push_back(mem_wdata_be); end
    if ((mem_we_le && we_prev_le) || (mem_we_be && we_prev_be)) we_long = we_long + 1;
    we_prev_le = mem_we_le;
    we_prev_be = mem_we_be;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic build_image(input int n, input bit good);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'd0;
    img_q.delete();
    img_q.push_back(8'(n));
    img_q.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      cs = cs ^ b;
      img_q.push_back(b);
    end
    img_q.push_back(good ? cs : ~cs);
  endtask

  // Reference: parse the whole image into expected writes and final status.
  task automatic model_image(input bit be);
    int n;
    logic [7:0] cs;
    logic [31:0] w;
    logic [7:0] x;
    exp_a.delete(); exp_d.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_wc = 0;
    n = int'(img_q[0]) + 256 * int'(img_q[1]);
    if (n > 64) begin
      exp_err = 1'b1;
      return;
    end
    cs = 8'd0;
    for (int k = 0; k < n; k++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++) begin
        x = img_q[2 + 4 * k + b];
        cs = cs ^ x;
        if (be) w = (w << 8) | 32'(x);
        else    w = w | (32'(x) << (8 * b));
      end
      exp_a.push_back(k);
      exp_d.push_back(w);
    end
    exp_wc = n;
    if (img_q[2 + 4 * n] == cs) exp_done = 1'b1;
    else                        exp_err  = 1'b1;
  endtask

  task automatic drive_image(input bit be, input bit b2b);
    foreach (img_q[i]) begin
      rx_data = img_q[i];
      if (be) rx_valid_be = 1'b1;
      else    rx_valid_le = 1'b1;
      @(negedge clk);
      rx_valid_le = 1'b0;
      rx_valid_be = 1'b0;
      if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_writes();
    le_a.delete(); le_d.delete(); be_a.delete(); be_d.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 7;
    if (cpu_rst_le !== 1'b1)       begin miscompares++; $display("FAIL reset_cpu_rst: got %0b want 1", cpu_rst_le); end
    if (mem_we_le !== 1'b0)        begin miscompares++; $display("FAIL reset_mem_we: got %0b want 0", mem_we_le); end
    if (mem_addr_le !== 6'd0)      begin miscompares++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr_le); end
    if (mem_wdata_le !== 32'd0)    begin miscompares++; $display("FAIL reset_mem_wdata: got %0h want 0", mem_wdata_le); end
    if (load_done_le !== 1'b0)     begin miscompares++; $display("FAIL reset_load_done: got %0b want 0", load_done_le); end
    if (load_err_le !== 1'b0)      begin miscompares++; $display("FAIL reset_load_err: got %0b want 0", load_err_le); end
    if (word_count_le !== 16'd0)   begin miscompares++; $display("FAIL reset_word_count: got %0d want 0", word_count_le); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_le_directed();
    img_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00, 8'h09};
    clear_writes();
    drive_image(1'b0, 1'b0);
    vectors += 5;
    if (le_a.size() !== 2) begin
      miscompares++; $display("FAIL le_write_count: got %0d want 2", le_a.size());
    end else begin
      if (le_a[0] !== 6'd0 || le_d[0] !== 32'h12345678) begin miscompares++; $display("FAIL le_word0: got %0h@%0d want 12345678@0", le_d[0], le_a[0]); end
      if (le_a[1] !== 6'd1 || le_d[1] !== 32'h00000001) begin miscompares++; $display("FAIL le_word1: got %0h@%0d want 1@1", le_d[1], le_a[1]); end
    end
    if (load_done_le !== 1'b1 || cpu_rst_le !== 1'b0) begin miscompares++; $display("FAIL le_done: got done=%0b cpu_rst=%0b want 1/0", load_done_le, cpu_rst_le); end
    if (word_count_le !== 16'd2) begin miscompares++; $display("FAIL le_word_count: got %0d want 2", word_count_le); end
  endtask

  task automatic test_be_directed();
    img_q = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    clear_writes();
    drive_image(1'b1, 1'b1);
    vectors += 3;
    if (be_a.size() !== 1 || be_d[0] !== 32'h12345678 || be_a[0] !== 6'd0) begin
      miscompares++; $display("FAIL be_word0: got %0d writes first=%0h want 1 write 12345678@0", be_a.size(), (be_d.size() > 0) ? be_d[0] : 32'd0);
    end
    if (we_long !== 0) begin miscompares++; $display("FAIL be_we_width: got %0d long pulses want 0", we_long); end
    if (load_done_be !== 1'b1) begin miscompares++; $display("FAIL be_done: got %0b want 1", load_done_be); end
  endtask

  task automatic test_bad_csum_reload();
    pulse_reload();
    img_q = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'hFF};
    clear_writes();
    drive_image(1'b0, 1'b0);
    vectors += 3;
    if (load_err_le !== 1'b1 || load_done_le !== 1'b0) begin miscompares++; $display("FAIL csum_err: got err=%0b done=%0b want 1/0", load_err_le, load_done_le); end
    if (cpu_rst_le !== 1'b1) begin miscompares++; $display("FAIL csum_cpu_rst: got %0b want 1", cpu_rst_le); end
    if (le_a.size() !== 1) begin miscompares++; $display("FAIL csum_writes: got %0d want 1", le_a.size()); end
    pulse_reload();
    build_image(1, 1'b1);
    drive_image(1'b0, 1'b0);
    vectors += 1;
    if (load_done_le !== 1'b1 || load_err_le !== 1'b0 || cpu_rst_le !== 1'b0) begin
      miscompares++; $display("FAIL reload_done: got done=%0b err=%0b cpu_rst=%0b want 1/0/0", load_done_le, load_err_le, cpu_rst_le);
    end
  endtask

  task automatic test_len_overflow();
    pulse_reload();
    clear_writes();
    rx_data = 8'h41; rx_valid_le = 1'b1; @(negedge clk);
    rx_data = 8'h00; @(negedge clk);
    rx_valid_le = 1'b0;
    vectors += 2;
    if (load_err_le !== 1'b1) begin miscompares++; $display("FAIL len_err: got %0b want 1 right after header", load_err_le); end
    img_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drive_image(1'b0, 1'b1);
    if (le_a.size() !== 0 || load_err_le !== 1'b1) begin miscompares++; $display("FAIL len_no_write: got %0d writes err=%0b want 0/1", le_a.size(), load_err_le); end
  endtask

  task automatic test_zero_len();
    pulse_reload();
    clear_writes();
    img_q = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03};
    drive_image(1'b0, 1'b0);
    vectors += 2;
    if (load_done_le !== 1'b1 || cpu_rst_le !== 1'b0) begin miscompares++; $display("FAIL zero_done: got done=%0b cpu_rst=%0b want 1/0", load_done_le, cpu_rst_le); end
    if (le_a.size() !== 0 || word_count_le !== 16'd0) begin miscompares++; $display("FAIL zero_writes: got %0d writes count=%0d want 0/0", le_a.size(), word_count_le); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      bit be;
      int n;
      logic [5:0]  oa[$];
      logic [31:0] od[$];
      logic        o_done, o_err, o_crst;
      logic [15:0] o_wc;
      be = 1'(it % 2);
      n = int'($urandom_range(1, 8));
      pulse_reload();
      build_image(n, ($urandom_range(0, 3) != 0));
      model_image(be);
      clear_writes();
      drive_image(be, 1'($urandom_range(0, 1)));
      if (be) begin oa = be_a; od = be_d; o_done = load_done_be; o_err = load_err_be; o_crst = cpu_rst_be; o_wc = word_count_be; end
      else    begin oa = le_a; od = le_d; o_done = load_done_le; o_err = load_err_le; o_crst = cpu_rst_le; o_wc = word_count_le; end
      vectors += 3;
      if (oa.size() !== exp_a.size()) begin
        miscompares++; $display("FAIL rnd%0d_writes: got %0d want %0d", it, oa.size(), exp_a.size());
      end else begin
        foreach (exp_a[i]) begin
          vectors++;
          if (oa[i] !== 6'(exp_a[i]) || od[i] !== exp_d[i]) begin
            miscompares++; $display("FAIL rnd%0d_word%0d: got %0h@%0d want %0h@%0d", it, i, od[i], oa[i], exp_d[i], exp_a[i]);
          end
        end
      end
      if (o_done !== exp_done || o_err !== exp_err || o_crst !== !exp_done) begin
        miscompares++; $display("FAIL rnd%0d_status: got done=%0b err=%0b cpu_rst=%0b want %0b/%0b/%0b", it, o_done, o_err, o_crst, exp_done, exp_err, !exp_done);
      end
      if (o_wc !== 16'(exp_wc)) begin miscompares++; $display("FAIL rnd%0d_count: got %0d want %0d", it, o_wc, exp_wc); end
    end
  endtask

  task automatic test_back_to_back();
    pulse_reload();
    build_image(4, 1'b1);
    clear_writes();
    for (int i = 0; i < 11; i++) begin
      rx_data = img_q[i];
      rx_valid_le = 1'b1;
      @(negedge clk);
    end
    #1;
    vectors += 2;
    if (le_a.size() !== 2) begin miscompares++; $display("FAIL b2b_mid_writes: got %0d want 2", le_a.size()); end
    if (cpu_rst_le !== 1'b1) begin miscompares++; $display("FAIL b2b_mid_cpu_rst: got %0b want 1", cpu_rst_le); end
    #2 rst = 1'b0;
    #1;
    rx_valid_le = 1'b0;
    vectors += 2;
    if (cpu_rst_le !== 1'b1 || mem_we_le !== 1'b0 || load_done_le !== 1'b0 || load_err_le !== 1'b0) begin
      miscompares++; $display("FAIL b2b_rst_ctrl: got cpu_rst=%0b we=%0b done=%0b err=%0b want 1/0/0/0", cpu_rst_le, mem_we_le, load_done_le, load_err_le);
    end
    if (mem_addr_le !== 6'd0 || word_count_le !== 16'd0 || mem_wdata_le !== 32'd0) begin
      miscompares++; $display("FAIL b2b_rst_data: got addr=%0d count=%0d wdata=%0h want 0/0/0", mem_addr_le, word_count_le, mem_wdata_le);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    build_image(4, 1'b1);
    model_image(1'b0);
    clear_writes();
    drive_image(1'b0, 1'b1);
    vectors += 3;
    if (le_a.size() !== exp_a.size()) begin
      miscompares++; $display("FAIL b2b_writes: got %0d want %0d", le_a.size(), exp_a.size());
    end else begin
      foreach (exp_a[i]) begin
        vectors++;
        if (le_a[i] !== 6'(exp_a[i]) || le_d[i] !== exp_d[i]) begin
          miscompares++; $display("FAIL b2b_word%0d: got %0h@%0d want %0h@%0d", i, le_d[i], le_a[i], exp_d[i], exp_a[i]);
        end
      end
    end
    if (load_done_le !== 1'b1) begin miscompares++; $display("FAIL b2b_done: got %0b want 1", load_done_le); end
    if (we_long !== 0) begin miscompares++; $display("FAIL b2b_we_width: got %0d long pulses want 0", we_long); end
  endtask

  initial begin
    test_reset();
    test_le_directed();
    test_be_directed();
    test_bad_csum_reload();
    test_len_overflow();
    test_zero_len();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
